// File: rtl/sn74_pkg.sv
// Shared definitions for the parametrised 74xx shift-register family.
package sn74_pkg;

   localparam int unsigned MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   // Ceiling log2, used for sizing the word counter from WIDTH.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      logic [32:0] pow;
      result = 0;
      pow    = 33'd1;
      while (pow < 33'(value)) begin
         pow    = pow << 1;
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sn74_shift_core.sv
// Shift stage with mode decode, word counter, word_done pulse and cascade tap.
module sn74_shift_core
   import sn74_pkg::*;
#(
   parameter int unsigned         WIDTH     = 4,
   parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
   input  logic             i_clk1,
   input  logic             i_reset1_n,
   input  logic [1:0]       i_mode,
   input  logic             i_sr_ser,
   input  logic             i_sl_ser,
   input  logic [WIDTH-1:0] i_d,
   input  logic             i_sclr_n,
   output logic [WIDTH-1:0] o_sh,
   output logic             o_ser_out,
   output logic             o_word_done
);

   localparam int unsigned     CNT_W    = (clog2(WIDTH) == 0) ? 1 : clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] r_sh;
   logic [CNT_W-1:0] r_cnt;
   logic             r_tap_lsb;
   logic             r_ser_out;
   logic             r_word_done;

   mode_e            w_mode;
   logic [WIDTH-1:0] w_sh_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_tap_lsb_nxt;
   logic             w_shift;
   logic             w_cnt_last;

   assign w_mode     = mode_e'(i_mode);
   assign w_cnt_last = (r_cnt == CNT_LAST);

   // Next-state decode; clear outranks every mode and leaves the tap alone.
   always_comb begin
      w_sh_nxt      = r_sh;
      w_cnt_nxt     = r_cnt;
      w_tap_lsb_nxt = r_tap_lsb;
      w_shift       = 1'b0;
      if (!i_sclr_n) begin
         w_sh_nxt  = '0;
         w_cnt_nxt = '0;
      end else begin
         case (w_mode)
            MODE_LOAD: begin
               w_sh_nxt      = i_d;
               w_cnt_nxt     = '0;
               w_tap_lsb_nxt = 1'b0;
            end
            MODE_SHR: begin
               w_sh_nxt      = {r_sh[WIDTH-2:0], i_sr_ser};
               w_shift       = 1'b1;
               w_tap_lsb_nxt = 1'b0;
            end
            MODE_SHL: begin
               w_sh_nxt      = {i_sl_ser, r_sh[WIDTH-1:1]};
               w_shift       = 1'b1;
               w_tap_lsb_nxt = 1'b1;
            end
            default: begin
            end
         endcase
         if (w_shift) begin
            w_cnt_nxt = w_cnt_last ? '0 : r_cnt + CNT_W'(1);
         end
      end
   end

   // ser_out is registered from the next-state tap so it tracks r_sh exactly.
   always_ff @(posedge i_clk1 or negedge i_reset1_n) begin
      if (!i_reset1_n) begin
         r_sh        <= RESET_VAL;
         r_cnt       <= '0;
         r_tap_lsb   <= 1'b0;
         r_ser_out   <= RESET_VAL[WIDTH-1];
         r_word_done <= 1'b0;
      end else begin
         r_sh        <= w_sh_nxt;
         r_cnt       <= w_cnt_nxt;
         r_tap_lsb   <= w_tap_lsb_nxt;
         r_ser_out   <= w_tap_lsb_nxt ? w_sh_nxt[0] : w_sh_nxt[WIDTH-1];
         r_word_done <= w_shift && w_cnt_last;
      end
   end

   assign o_sh        = r_sh;
   assign o_ser_out   = r_ser_out;
   assign o_word_done = r_word_done;

endmodule

// File: rtl/sn74_univ_shift_reg.sv
// 74HC194/595-style universal shift register: shift core, optional storage
// register and oe-gated true/complement outputs.
module sn74_univ_shift_reg
   import sn74_pkg::*;
#(
   parameter int unsigned      WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int unsigned      STORAGE   = 1
) (
   input  logic             clk1,
   input  logic             reset1_n,
   input  logic [1:0]       mode,
   input  logic             sr_ser,
   input  logic             sl_ser,
   input  logic [WIDTH-1:0] d,
   input  logic             sclr_n,
   input  logic             latch,
   input  logic             oe_n,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n,
   output logic             ser_out,
   output logic             word_done
);

   logic [WIDTH-1:0] w_sh;
   logic [WIDTH-1:0] w_raw;

   sn74_shift_core #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_core (
      .i_clk1      (clk1),
      .i_reset1_n  (reset1_n),
      .i_mode      (mode),
      .i_sr_ser    (sr_ser),
      .i_sl_ser    (sl_ser),
      .i_d         (d),
      .i_sclr_n    (sclr_n),
      .o_sh        (w_sh),
      .o_ser_out   (ser_out),
      .o_word_done (word_done)
   );

   if (STORAGE != 0) begin : g_storage
      logic [WIDTH-1:0] r_store;

      // Latch captures the pre-edge shift stage, even alongside a clear or shift.
      always_ff @(posedge clk1 or negedge reset1_n) begin
         if (!reset1_n) begin
            r_store <= RESET_VAL;
         end else if (latch) begin
            r_store <= w_sh;
         end
      end

      assign w_raw = r_store;
   end else begin : g_direct
      logic w_unused_latch;
      assign w_unused_latch = latch;
      assign w_raw          = w_sh;
   end

   // Output enable is a zero-latency gate; both polarities drop to 0 when disabled.
   always_comb begin
      q   = '0;
      q_n = '0;
      if (!oe_n) begin
         q   = w_raw;
         q_n = ~w_raw;
      end
   end

endmodule

// File: doc/sn74_univ_shift_reg.md
Name: sn74_univ_shift_reg

Overview:
- Parametrised successor to the team's 74xx flip-flop blocks: a 74HC194/74HC595-style universal shift register with a WIDTH-bit shift stage and an optional storage (output) register.
- Supports hold, shift-right, shift-left and parallel-load modes.
- Has synchronous clear, a latch strobe, an output enable, true and complemented outputs, and a word-complete counter.
- Sits on the STEPFPGA pin-mapped 74xx layer; a pin-wrapper maps chip pins onto these ports.

Parameters:
- WIDTH, 4, number of register bits (>=2).
- RESET_VAL, 0, value loaded into the shift and storage stages on reset (WIDTH bits).
- STORAGE, 1, 1 = q driven from the storage register (595 style); 0 = q driven directly from the shift stage (194 style).

Ports:
- clk1  in  1  clock; all state changes on its rising edge.
- reset1_n  in  1  asynchronous active-low reset.
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sr_ser  in  1  serial input for shift right (enters bit 0).
- sl_ser  in  1  serial input for shift left (enters bit WIDTH-1).
- d  in  WIDTH  parallel load data.
- sclr_n  in  1  synchronous clear, active-low.
- latch  in  1  copy shift stage into storage register (STORAGE=1 only).
- oe_n  in  1  output enable, active-low.
- q  out  WIDTH  register outputs.
- q_n  out  WIDTH  complement of q.
- ser_out  out  1  cascade output.
- word_done  out  1  one-cycle pulse on every WIDTH-th consecutive shift.

Behaviour:
- Reset (reset1_n=0, asynchronous, no clock needed):
  - shift stage = RESET_VAL; storage = RESET_VAL; shift counter = 0; word_done = 0.
  - Outputs settle to those values, with q gated by oe_n as defined below.
- Priority at each clk1 rising edge, highest first:
  1. sclr_n=0: shift stage <= 0, counter <= 0. mode is ignored. latch still acts, per the latch rule below.
  2. mode=11: shift stage <= d, counter <= 0.
  3. mode=01: sh <= {sh[WIDTH-2:0], sr_ser}; counter increments.
  4. mode=10: sh <= {sl_ser, sh[WIDTH-1:1]}; counter increments.
  5. mode=00: no change; counter holds.
- Counter: ceil(log2 WIDTH) bits.
  - When a shift occurs with counter = WIDTH-1, the counter wraps to 0 and word_done=1 for exactly the next cycle.
  - A direction change mid-word does not reset the counter.
- Latch (STORAGE=1): latch=1 at an edge copies the pre-edge shift stage into storage.
  - Simultaneous shift+latch stores the old value; the new shift result appears only on the next latch.
  - Simultaneous sclr_n=0 + latch=1 stores the pre-clear value.
- STORAGE=0: the storage register and latch are absent; q follows the shift stage.
- Output selection:
  - raw = storage (STORAGE=1) or shift stage (STORAGE=0).
  - oe_n=0: q = raw, q_n = ~raw.
  - oe_n=1: q = 0 and q_n = 0 (FPGA substitute for high-Z).
  - oe_n is combinational with zero latency and does not affect internal state.
- ser_out:
  - Equals sh[WIDTH-1] when the last non-hold mode was shift right or load; equals sh[0] after shift left.
  - Reset selects the sh[WIDTH-1] tap.
  - Taken from the shift stage and not gated by oe_n, so devices can be cascaded.
- Latency: shift-stage effects are visible on q one edge after the operation (STORAGE=0), or one edge after latch (STORAGE=1).
- Reset asserted mid-word: counter is cleared and any pending word_done pulse is cancelled.

Decomposition:
- Shared package sn74_pkg:
  - mode encodings MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD;
  - a clog2 helper function.
- Sub-module sn74_shift_core: shift stage, mode decode, counter, word_done and ser_out tap select.
- Top level adds the storage register, latch and oe gating.

Test Plan (WIDTH=4, RESET_VAL=0, STORAGE=1 unless noted):
- Reset, then load d=4'b1010, pulse latch, oe_n=0 -> q=1010, q_n=0101, ser_out=1.
- From 0000, 4 edges of mode=01 with sr_ser=1,0,1,1 -> sh=1011; word_done high in the cycle after the 4th edge only; q stays 0000 until latch, then reads 1011.
- Load 1000, one mode=10 edge with sl_ser=1, latch asserted on that same edge -> storage=1000 (pre-edge value), sh=1100, ser_out=sh[0]=0; next latch -> q=1100.
- sh=1111 with sclr_n=0, mode=11, d=0101 on one edge -> sh=0000 (clear wins), counter=0.
- Two shift-right edges, then reset1_n pulsed low between clock edges -> q=0000 immediately; counter 0; no word_done after two further shifts.
- STORAGE=0, oe_n toggled 0->1 with q=0110 -> q=0000 and q_n=0000 while oe_n=1; values restored when oe_n returns to 0, with no clock required.
